// File: rtl/teng_stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : teng_stim_sequencer
//  Description : Steps the TENG sine generator through a +sin / -sin / +sin
//                burst, holding each phase for L cycles, repeated N times.
//  Revision    : 1.0 - initial release
// ============================================================================

module teng_stim_sequencer #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   phase_len,
    input  logic [BURST_W-1:0] num_bursts,
    output logic               busy,
    output logic               done,
    output logic               gen_en,
    output logic               polarity,
    output logic [1:0]         phase_idx,
    output logic [BURST_W-1:0] burst_cnt
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_pos_a = 3'd1;
    localparam logic [2:0] c_st_neg   = 3'd2;
    localparam logic [2:0] c_st_pos_b = 3'd3;
    localparam logic [2:0] c_st_fin   = 3'd4;

    localparam logic [CNT_W-1:0]   c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] c_burst_one = {{(BURST_W-1){1'b0}}, 1'b1};

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_phase_cnt;
    logic [CNT_W-1:0]   r_last_cnt;
    logic [BURST_W-1:0] r_num_bursts;
    logic [BURST_W-1:0] r_burst_cnt;

    logic w_run;
    logic w_phase_end;
    logic w_last_burst;
    logic w_accept;
    logic w_burst_adv;

    assign w_run        = (r_state == c_st_pos_a) || (r_state == c_st_neg) ||
                          (r_state == c_st_pos_b);
    assign w_phase_end  = (r_phase_cnt == r_last_cnt);
    // A run is only entered with r_num_bursts >= 1, so the subtraction is safe.
    assign w_last_burst = (r_burst_cnt == (r_num_bursts - c_burst_one));
    assign w_accept     = (r_state == c_st_idle) && start && !abort;
    assign w_burst_adv  = (r_state == c_st_pos_b) && !abort && w_phase_end &&
                          !w_last_burst;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = (num_bursts == '0) ? c_st_fin : c_st_pos_a;
                end
            end
            c_st_pos_a: begin
                if (abort) begin
                    w_state_nxt = c_st_idle;
                end else if (w_phase_end) begin
                    w_state_nxt = c_st_neg;
                end
            end
            c_st_neg: begin
                if (abort) begin
                    w_state_nxt = c_st_idle;
                end else if (w_phase_end) begin
                    w_state_nxt = c_st_pos_b;
                end
            end
            c_st_pos_b: begin
                if (abort) begin
                    w_state_nxt = c_st_idle;
                end else if (w_phase_end) begin
                    w_state_nxt = w_last_burst ? c_st_fin : c_st_pos_a;
                end
            end
            c_st_fin: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_phase_cnt  <= '0;
            r_last_cnt   <= '0;
            r_num_bursts <= '0;
            r_burst_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Counter restarts on every phase entry, including POS_B -> POS_A.
            if (!w_run || (w_state_nxt != r_state)) begin
                r_phase_cnt <= '0;
            end else begin
                r_phase_cnt <= r_phase_cnt + c_cnt_one;
            end

            if (w_accept) begin
                r_last_cnt   <= (phase_len == '0) ? '0 : (phase_len - c_cnt_one);
                r_num_bursts <= num_bursts;
                r_burst_cnt  <= '0;
            end else if (w_burst_adv) begin
                r_burst_cnt <= r_burst_cnt + c_burst_one;
            end
        end
    end

    always_comb begin
        busy      = w_run;
        gen_en    = w_run;
        done      = (r_state == c_st_fin);
        polarity  = (r_state != c_st_neg);
        phase_idx = 2'd0;
        if (r_state == c_st_neg) begin
            phase_idx = 2'd1;
        end else if (r_state == c_st_pos_b) begin
            phase_idx = 2'd2;
        end
        burst_cnt = r_burst_cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_teng_stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_teng_stim_sequencer
//  Description : Table-driven, scoreboard-checked bench for the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_teng_stim_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       gen_en;
        logic       polarity;
        logic [1:0] phase_idx;
        logic [7:0] burst_cnt;
    } obs_t;

    typedef struct {
        int  len;
        int  bursts;
        bit  chg;
        int  exp_gens;
        int  exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] phase_len;
    logic [7:0]  num_bursts;
    logic        busy;
    logic        done;
    logic        gen_en;
    logic        polarity;
    logic [1:0]  phase_idx;
    logic [7:0]  burst_cnt;

    int   checks   = 0;
    int   failures = 0;
    obs_t q[$];
    obs_t last_obs;
    logic [7:0] prev_bc;

    always #5 clk = ~clk;

    teng_stim_sequencer #(
        .CNT_W   (16),
        .BURST_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .phase_len  (phase_len),
        .num_bursts (num_bursts),
        .busy       (busy),
        .done       (done),
        .gen_en     (gen_en),
        .polarity   (polarity),
        .phase_idx  (phase_idx),
        .burst_cnt  (burst_cnt)
    );

    function automatic obs_t idle_obs(input logic [7:0] bc);
        obs_t o;
        o.busy = 1'b0; o.done = 1'b0; o.gen_en = 1'b0; o.polarity = 1'b1;
        o.phase_idx = 2'd0; o.burst_cnt = bc;
        return o;
    endfunction

    // Expected outputs in run cycle c (c = 0 is the cycle start is driven).
    function automatic obs_t model(input int len, input int n, input int c,
                                   input logic [7:0] pbc);
        obs_t o;
        int le, tot, idx;
        le  = (len == 0) ? 1 : len;
        tot = 3 * le * n;
        o = idle_obs((c == 0) ? pbc : 8'((n == 0) ? 0 : n - 1));
        if (c >= 1 && c <= tot) begin
            idx         = c - 1;
            o.busy      = 1'b1;
            o.gen_en    = 1'b1;
            o.phase_idx = 2'((idx % (3 * le)) / le);
            o.polarity  = (o.phase_idx != 2'd1);
            o.burst_cnt = 8'(idx / (3 * le));
        end else if (c == tot + 1) begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    // One clock: push expectation, drive this cycle's inputs, compare at negedge.
    task automatic tick(input logic s, input logic a, input logic r,
                        input logic [15:0] pl, input logic [7:0] nb,
                        input obs_t e, input string name);
        obs_t got, want;
        @(posedge clk);
        #1;
        q.push_back(e);
        start = s; abort = a; rst = r; phase_len = pl; num_bursts = nb;
        @(negedge clk);
        got.busy = busy; got.done = done; got.gen_en = gen_en;
        got.polarity = polarity; got.phase_idx = phase_idx; got.burst_cnt = burst_cnt;
        last_obs = got;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
        end else begin
            want = q.pop_front();
            if (got !== want) begin
                failures++;
                $display("FAIL %s t=%0t: got busy=%0b done=%0b gen=%0b pol=%0b idx=%0d bc=%0d, want busy=%0b done=%0b gen=%0b pol=%0b idx=%0d bc=%0d",
                         name, $time, got.busy, got.done, got.gen_en, got.polarity,
                         got.phase_idx, got.burst_cnt, want.busy, want.done,
                         want.gen_en, want.polarity, want.phase_idx, want.burst_cnt);
            end
        end
    endtask

    task automatic run_cfg(input int len, input int n, input bit chg,
                           output int gens, output int done_at);
        int tot;
        logic [15:0] pl;
        logic [7:0]  nb;
        tot     = 3 * ((len == 0) ? 1 : len) * n;
        gens    = 0;
        done_at = -1;
        for (int c = 0; c <= tot + 2; c++) begin
            pl = 16'(len);
            nb = 8'(n);
            if (chg && c > 0) begin
                pl = 16'($urandom_range(1, 200));
                nb = 8'($urandom_range(1, 200));
            end
            tick(c == 0, 1'b0, 1'b0, pl, nb, model(len, n, c, prev_bc), "run");
            if (last_obs.gen_en === 1'b1) gens++;
            if (last_obs.done === 1'b1) done_at = (done_at < 0) ? c : -2;
        end
        prev_bc = 8'((n == 0) ? 0 : n - 1);
    endtask

    vec_t vecs[7];

    initial begin
        int gens, done_at;

        vecs[0] = '{len: 3,  bursts: 1,   chg: 1'b0, exp_gens: 9,   exp_done: 10};
        vecs[1] = '{len: 2,  bursts: 3,   chg: 1'b1, exp_gens: 18,  exp_done: 19};
        vecs[2] = '{len: 7,  bursts: 0,   chg: 1'b0, exp_gens: 0,   exp_done: 1};
        vecs[3] = '{len: 0,  bursts: 1,   chg: 1'b0, exp_gens: 3,   exp_done: 4};
        vecs[4] = '{len: 5,  bursts: 2,   chg: 1'b0, exp_gens: 30,  exp_done: 31};
        vecs[5] = '{len: 1,  bursts: 255, chg: 1'b0, exp_gens: 765, exp_done: 766};
        vecs[6] = '{len: 4,  bursts: 2,   chg: 1'b1, exp_gens: 24,  exp_done: 25};

        rst = 1'b1; start = 1'b0; abort = 1'b0; phase_len = '0; num_bursts = '0;
        prev_bc = 8'd0;
        @(posedge clk);
        tick(1'b0, 1'b0, 1'b0, 16'd0, 8'd0, idle_obs(8'd0), "reset_state");

        // Abort in IDLE wins over a simultaneous start.
        tick(1'b1, 1'b1, 1'b0, 16'd3, 8'd1, idle_obs(8'd0), "idle_abort_drive");
        tick(1'b0, 1'b0, 1'b0, 16'd3, 8'd1, idle_obs(8'd0), "idle_abort");
        tick(1'b0, 1'b0, 1'b0, 16'd3, 8'd1, idle_obs(8'd0), "idle_abort_hold");

        // Reset during the second burst: idle next cycle, burst_cnt cleared.
        for (int c = 0; c <= 13; c++)
            tick(c == 0, 1'b0, 1'b0, 16'd4, 8'd2, model(4, 2, c, prev_bc), "rst_run");
        tick(1'b0, 1'b0, 1'b1, 16'd4, 8'd2, model(4, 2, 14, prev_bc), "rst_assert");
        tick(1'b0, 1'b0, 1'b1, 16'd4, 8'd2, idle_obs(8'd0), "rst_mid_run");
        tick(1'b0, 1'b0, 1'b1, 16'd4, 8'd2, idle_obs(8'd0), "rst_hold");
        tick(1'b0, 1'b0, 1'b0, 16'd4, 8'd2, idle_obs(8'd0), "rst_release");
        tick(1'b0, 1'b0, 1'b0, 16'd4, 8'd2, idle_obs(8'd0), "rst_after");
        prev_bc = 8'd0;

        // Abort during NEG of the first burst: no done, burst_cnt holds.
        for (int c = 0; c <= 7; c++)
            tick(c == 0, 1'b0, 1'b0, 16'd5, 8'd2, model(5, 2, c, prev_bc), "abort_run");
        tick(1'b0, 1'b1, 1'b0, 16'd5, 8'd2, model(5, 2, 8, prev_bc), "abort_drive");
        for (int c = 9; c <= 11; c++)
            tick(1'b0, 1'b0, 1'b0, 16'd5, 8'd2, idle_obs(8'd0), "abort_idle");

        // Start held through the whole run: one done, then a fresh start.
        for (int c = 0; c <= 7; c++)
            tick(1'b1, 1'b0, 1'b0, 16'd2, 8'd1, model(2, 1, c, prev_bc), "hold_start");
        tick(1'b1, 1'b0, 1'b0, 16'd2, 8'd1, idle_obs(8'd0), "hold_idle_accept");
        tick(1'b0, 1'b0, 1'b0, 16'd2, 8'd1, model(2, 1, 1, 8'd0), "hold_restart");
        tick(1'b0, 1'b1, 1'b0, 16'd2, 8'd1, model(2, 1, 2, 8'd0), "hold_abort");
        tick(1'b0, 1'b0, 1'b0, 16'd2, 8'd1, idle_obs(8'd0), "hold_aborted");
        prev_bc = 8'd0;

        for (int i = 0; i < 7; i++) begin
            run_cfg(vecs[i].len, vecs[i].bursts, vecs[i].chg, gens, done_at);
            checks++;
            if (gens != vecs[i].exp_gens) begin
                failures++;
                $display("FAIL vec%0d_gen_cycles: got %0d want %0d", i, gens, vecs[i].exp_gens);
            end
            checks++;
            if (done_at != vecs[i].exp_done) begin
                failures++;
                $display("FAIL vec%0d_done_cycle: got %0d want %0d", i, done_at, vecs[i].exp_done);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
